// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array output stage.
//   N_PE        default number of PE results per frame
//   ACC_W       default accumulator width per result (multiple of 8)
//   NBYTES      bytes per frame for the default geometry
//   ST_IDLE/ST_SEND  legacy-compatible state codes
//   ser_state_t serializer state type built on those codes
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N_PE   = 4;
    localparam int ACC_W  = 16;
    localparam int NBYTES = N_PE * ACC_W / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } ser_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// -----------------------------------------------------------------------------
// sync_rise_detect
// Brings an asynchronous pin into the clk domain through two flops and emits a
// single-cycle pulse on each rising edge of the synchronized value.
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, clears all flops
//   async_in  in   asynchronous input pin
//   rise      out  1-cycle pulse, high for the cycle after sync2 goes 0->1
// -----------------------------------------------------------------------------
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A pin held high produces only one pulse because prev catches up with sync2.
    assign rise = sync2 & ~prev;

endmodule

// File: rtl/systolic_result_serializer.sv
// -----------------------------------------------------------------------------
// systolic_result_serializer
// Captures one frame of N_PE accumulator results on res_strobe and streams it
// out one byte at a time (PE0 first, LSB byte first) under a valid/ack pin
// handshake suited to a slow asynchronous host.
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   res_strobe  in   1-cycle pulse, res_data holds a complete frame
//   res_data    in   N_PE*ACC_W results, PE0 in the low ACC_W bits
//   res_ready   out  idle, a strobe will be accepted
//   byte_out    out  current frame byte (0 while idle)
//   byte_valid  out  byte_out is valid and waiting for a host ack
//   byte_first  out  byte_out is byte 0 of the frame
//   host_ack    in   asynchronous ack pin, each rising edge consumes one byte
//   ovr_clear   in   synchronous clear of the overrun flag
//   overrun     out  sticky flag, a strobe arrived while busy
// -----------------------------------------------------------------------------
module systolic_result_serializer #(
    parameter int N_PE  = 4,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_strobe,
    input  logic [N_PE*ACC_W-1:0] res_data,
    output logic                  res_ready,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    output logic                  byte_first,
    input  logic                  host_ack,
    input  logic                  ovr_clear,
    output logic                  overrun
);

    import systolic_pkg::*;

    localparam int BUF_W     = N_PE * ACC_W;
    localparam int NUM_BYTES = BUF_W / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    ser_state_t       state;
    logic [BUF_W-1:0] frame_buf;
    logic [IDX_W-1:0] idx;
    logic             ack_rise;

    sync_rise_detect u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (host_ack),
        .rise     (ack_rise)
    );

    // Frame capture and byte sequencing. Ack pulses arriving while idle are
    // ignored, and a strobe is only taken in IDLE, so a strobe on the same edge
    // as the final ack still sees the block as busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_buf <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (res_strobe) begin
                        frame_buf <= res_data;
                        idx       <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (ack_rise) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (res_strobe && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (ovr_clear) begin
            overrun <= 1'b0;
        end
    end

    assign byte_valid = (state == SEND);
    assign res_ready  = (state == IDLE);
    assign byte_first = byte_valid && (idx == '0);

    // {idx, 3'b000} is idx*8, the bit offset of the selected byte.
    assign byte_out = byte_valid ? frame_buf[{idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_systolic_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_serializer
// Self-checking bench for systolic_result_serializer. A frame-level reference
// model (current frame, bytes consumed, busy, overrun) predicts every output.
// -----------------------------------------------------------------------------
module tb_systolic_result_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_strobe;
    logic [63:0] res_data;
    logic        res_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_first;
    logic        host_ack;
    logic        ovr_clear;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] mFrame;
    bit          mBusy;
    int          mPos;
    bit          mOvr;

    systolic_result_serializer #(
        .N_PE  (4),
        .ACC_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_strobe (res_strobe),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_first (byte_first),
        .host_ack   (host_ack),
        .ovr_clear  (ovr_clear),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] expByte();
        logic [63:0] shifted;
        shifted = mFrame >> (8 * mPos);
        return mBusy ? shifted[7:0] : 8'h00;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 64'(byte_valid), 64'(mBusy));
        checkOutput({tag, ".first"}, 64'(byte_first), 64'(mBusy && mPos == 0));
        checkOutput({tag, ".byte"},  64'(byte_out),   64'(expByte()));
        checkOutput({tag, ".ready"}, 64'(res_ready),  64'(!mBusy));
        checkOutput({tag, ".ovr"},   64'(overrun),    64'(mOvr));
    endtask

    task automatic modelStrobe(input logic [63:0] data, input bit clr);
        if (mBusy) begin
            mOvr = 1'b1;
        end else begin
            if (clr) mOvr = 1'b0;
            mFrame = data;
            mBusy  = 1'b1;
            mPos   = 0;
        end
    endtask

    task automatic modelConsume();
        if (mBusy) begin
            if (mPos == 7) begin
                mBusy = 1'b0;
                mPos  = 0;
            end else begin
                mPos++;
            end
        end
    endtask

    task automatic modelReset();
        mFrame = '0;
        mBusy  = 1'b0;
        mPos   = 0;
        mOvr   = 1'b0;
    endtask

    // Pulse res_strobe for one cycle, optionally with ovr_clear alongside.
    task automatic applyStimulus(input logic [63:0] data, input bit clr);
        res_strobe = 1'b1;
        res_data   = data;
        ovr_clear  = clr;
        @(negedge clk);
        modelStrobe(data, clr);
        res_strobe = 1'b0;
        ovr_clear  = 1'b0;
        checkAll("strobe");
    endtask

    task automatic clearOverrun();
        ovr_clear = 1'b1;
        @(negedge clk);
        mOvr      = 1'b0;
        ovr_clear = 1'b0;
        checkAll("clear");
    endtask

    // Raise host_ack for 'hold' cycles; the byte is consumed on the third
    // rising clock edge after the pin rises. strobeAt (nonzero) raises
    // res_strobe after that many edges so it lands on edge strobeAt+1.
    task automatic ackByte(input int hold, input int strobeAt, input logic [63:0] data);
        bit stbPending;
        stbPending = 1'b0;
        host_ack   = 1'b1;
        for (int i = 1; i <= hold + 3; i++) begin
            @(negedge clk);
            if (i == hold) host_ack = 1'b0;
            if (stbPending) begin
                modelStrobe(data, 1'b0);
                stbPending = 1'b0;
                res_strobe = 1'b0;
            end
            if (i == 3) modelConsume();
            if (strobeAt != 0 && i == strobeAt) begin
                res_strobe = 1'b1;
                res_data   = data;
                stbPending = 1'b1;
            end
            checkAll($sformatf("ack%0d", i));
        end
    endtask

    function automatic logic [63:0] randFrame();
        return {$urandom, $urandom};
    endfunction

    logic [7:0] known [8];

    initial begin
        known = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        rst_n      = 1'b0;
        res_strobe = 1'b0;
        res_data   = '0;
        host_ack   = 1'b0;
        ovr_clear  = 1'b0;
        modelReset();

        // Reset state
        repeat (2) @(negedge clk);
        checkAll("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("post_reset");

        // Single known frame
        applyStimulus(64'h0004_0003_0002_0001, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checkOutput($sformatf("known_byte%0d", b), 64'(byte_out), 64'(known[b]));
            ackByte(1, 0, '0);
        end
        checkOutput("known_done_ready", 64'(res_ready), 64'd1);

        // Ack held high for 20 cycles consumes exactly one byte
        applyStimulus(randFrame(), 1'b0);
        ackByte(20, 0, '0);
        checkOutput("held_ack_pos", 64'(mPos), 64'd1);
        for (int b = 1; b < 8; b++) ackByte($urandom_range(1, 5), 0, '0);

        // Overrun at byte 3; remaining bytes come from the first frame
        applyStimulus(randFrame(), 1'b0);
        for (int b = 0; b < 3; b++) ackByte(2, 0, '0);
        applyStimulus(randFrame(), 1'b0);
        for (int b = 3; b < 8; b++) ackByte(2, 0, '0);
        clearOverrun();

        // Clear and strobe in the same busy cycle: set wins
        applyStimulus(randFrame(), 1'b0);
        ackByte(1, 0, '0);
        applyStimulus(randFrame(), 1'b1);
        for (int b = 1; b < 8; b++) ackByte(1, 0, '0);
        clearOverrun();

        // Back-to-back: strobe on the edge after the final ack is accepted
        applyStimulus(randFrame(), 1'b0);
        for (int b = 0; b < 7; b++) ackByte(1, 0, '0);
        ackByte(2, 3, randFrame());
        // Strobe coincident with the final-ack edge is an overrun
        for (int b = 0; b < 7; b++) ackByte(1, 0, '0);
        ackByte(2, 2, randFrame());
        clearOverrun();

        // Reset mid-frame at byte 5 with overrun set
        applyStimulus(randFrame(), 1'b0);
        for (int b = 0; b < 5; b++) ackByte(1, 0, '0);
        applyStimulus(randFrame(), 1'b0);
        rst_n    = 1'b0;
        host_ack = 1'b0;
        #1;
        modelReset();
        checkAll("mid_reset");
        @(negedge clk);
        checkAll("mid_reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("mid_reset_release");
        applyStimulus(randFrame(), 1'b0);
        for (int b = 0; b < 8; b++) ackByte(1, 0, '0);

        // Randomized frames with stray idle acks, overruns and clears
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) ackByte($urandom_range(1, 4), 0, '0);
            applyStimulus(randFrame(), 1'($urandom_range(0, 1)));
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) applyStimulus(randFrame(), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 4) == 0) clearOverrun();
                ackByte($urandom_range(1, 20), 0, '0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
